// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: issue/source/branch inputs and forward/stall/flush outputs of the hazard unit
//   master: datapath side; drives the iss_*, src_* and branch_taken_e signals and reads the controls
//   slave : hazard unit side; reads the datapath signals and drives fwd_sel, stall_*, flush_*, stall_count
interface hazard_scoreboard_if #(
    parameter int NUM_SRC = 4,
    parameter int NUM_WP  = 2,
    parameter int REG_AW  = 4,
    parameter int FWD_W   = 3
) ();
    logic                        iss_valid;
    logic [NUM_WP-1:0]           iss_we;
    logic [NUM_WP*REG_AW-1:0]    iss_wa;
    logic                        iss_load;
    logic [NUM_SRC*REG_AW-1:0]   src_ra_d;
    logic [NUM_SRC-1:0]          src_used_d;
    logic [NUM_SRC*REG_AW-1:0]   src_ra_e;
    logic [NUM_SRC-1:0]          src_used_e;
    logic                        branch_taken_e;
    logic [NUM_SRC*FWD_W-1:0]    fwd_sel;
    logic                        stall_f;
    logic                        stall_d;
    logic                        flush_d;
    logic                        flush_e;
    logic [31:0]                 stall_count;

    modport master (
        output iss_valid, iss_we, iss_wa, iss_load, src_ra_d, src_used_d,
               src_ra_e, src_used_e, branch_taken_e,
        input  fwd_sel, stall_f, stall_d, flush_d, flush_e, stall_count
    );

    modport slave (
        input  iss_valid, iss_we, iss_wa, iss_load, src_ra_d, src_used_d,
               src_ra_e, src_used_e, branch_taken_e,
        output fwd_sel, stall_f, stall_d, flush_d, flush_e, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destination tags and drives forward selects, load-use stall and flushes
//   clk   : rising-edge clock
//   reset : synchronous active-high; clears all tags and the stall counter
//   bus   : hazard_scoreboard_if.slave (issue fields, Decode/Execute sources, branch in; controls out)
module hazard_scoreboard #(
    parameter int NUM_SRC    = 4,
    parameter int NUM_WP     = 2,
    parameter int DEPTH      = 2,
    parameter int REG_AW     = 4,
    parameter int FWD_W      = 3,
    parameter int LOAD_AVAIL = 2,
    parameter int PC_REG     = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_scoreboard_if.slave   bus
);
    typedef struct packed {
        logic                     valid;
        logic [NUM_WP-1:0]        we;
        logic [NUM_WP*REG_AW-1:0] wa;
        logic                     load;
    } tag_t;

    localparam logic [REG_AW-1:0] PC = REG_AW'(PC_REG);

    tag_t                      ent [0:DEPTH];
    tag_t                      iss_tag;
    logic                      lu;
    logic                      branch;
    logic                      flush_e;
    logic [NUM_SRC*FWD_W-1:0]  fwd;
    logic [31:0]               cnt;

    assign branch  = bus.branch_taken_e;
    assign flush_e = lu || branch;
    assign iss_tag = {1'b1, bus.iss_we, bus.iss_wa, bus.iss_load};

    // Load-use: a load whose port0 result is not yet available when the Decode reader reaches Execute.
    always_comb begin
        lu = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            for (int k = 0; k <= LOAD_AVAIL - 2; k++)
                if (ent[k].valid && ent[k].load && ent[k].we[0] &&
                    ent[k].wa[REG_AW-1:0] == bus.src_ra_d[i*REG_AW +: REG_AW] &&
                    bus.src_used_d[i] && bus.src_ra_d[i*REG_AW +: REG_AW] != PC)
                    lu = 1'b1;
    end

    // Scan oldest-to-youngest, highest port first, so the youngest stage / lowest port overwrites last.
    always_comb begin
        fwd = '0;
        for (int i = 0; i < NUM_SRC; i++)
            for (int s = DEPTH; s >= 1; s--)
                for (int p = NUM_WP - 1; p >= 0; p--)
                    if (ent[s].valid && ent[s].we[p] &&
                        ent[s].wa[p*REG_AW +: REG_AW] == bus.src_ra_e[i*REG_AW +: REG_AW] &&
                        !(p == 0 && ent[s].load && s < LOAD_AVAIL) &&
                        bus.src_used_e[i] && bus.src_ra_e[i*REG_AW +: REG_AW] != PC)
                        fwd[i*FWD_W +: FWD_W] = FWD_W'(1 + (s - 1) * NUM_WP + p);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k <= DEPTH; k++)
                ent[k] <= '0;
            cnt <= '0;
        end else begin
            ent[0] <= (bus.iss_valid && !flush_e) ? iss_tag : '0;
            for (int k = 1; k <= DEPTH; k++)
                ent[k] <= ent[k-1];
            if (lu && !branch && cnt != 32'hFFFF_FFFF)
                cnt <= cnt + 32'd1;
        end
    end

    assign bus.fwd_sel     = fwd;
    assign bus.stall_f     = lu && !branch;
    assign bus.stall_d     = lu && !branch;
    assign bus.flush_d     = branch;
    assign bus.flush_e     = flush_e;
    assign bus.stall_count = cnt;
endmodule
